// File: rtl/pll_mdrp_ctrl.sv
// pll_mdrp_ctrl: initiator for the GW5A PLLA dynamic-reconfiguration (MD) port.
// A host issues single-byte register reads/writes. Each command runs an ADDR pulse,
// then a DATA pulse. Reads add a CAPT pulse that samples md_rdo. Writes may
// optionally pulse pll_reset and then wait for lock, with a timeout.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_write/addr/wdata  command fields, latched on accept
//   cmd_relock            write only: run reset/lock sequence after data phase
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             last read data (held until next read)
//   rsp_err               lock timeout flag, valid with rsp_valid
//   busy                  high whenever not IDLE
//   pll_lock, pll_reset   PLL lock (async) in, PLL reset out
//   md_clk/opc/ainc/wdi   MD port outputs; md_rdo MD read data in
module pll_mdrp_ctrl #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned RST_CYCLES   = 32,
  parameter int unsigned LOCK_TIMEOUT = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  input  logic       cmd_relock,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       md_clk,
  output logic [1:0] md_opc,
  output logic       md_ainc,
  output logic [7:0] md_wdi,
  input  logic [7:0] md_rdo
);

  localparam logic [1:0] OpcNop   = 2'b00;
  localparam logic [1:0] OpcWrite = 2'b01;
  localparam logic [1:0] OpcRead  = 2'b10;
  localparam logic [1:0] OpcAddr  = 2'b11;

  localparam logic [31:0] HalfLen   = 32'(CLK_DIV);
  localparam logic [31:0] PulseLast = 32'(2 * CLK_DIV - 1);
  localparam logic [31:0] RstLast   = 32'(RST_CYCLES - 1);
  localparam logic [31:0] LockLast  = 32'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StAddr, StData, StCapt, StRst, StLockw, StResp
  } state_t;

  state_t      state;
  logic [31:0] cnt;        // pulse phase, reset hold or lock-wait counter
  logic        pulse_on;   // an MD pulse is in progress
  logic        pulse_end;  // last cycle of the current pulse
  logic [7:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        write_q;
  logic        relock_q;
  logic        lock_meta;
  logic        lock_s;

  assign pulse_end = pulse_on && (cnt == PulseLast);
  assign cmd_ready = (state == StIdle);
  assign busy      = (state != StIdle);
  assign md_ainc   = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      cnt       <= '0;
      pulse_on  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      relock_q  <= 1'b0;
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      pll_reset <= 1'b0;
      md_clk    <= 1'b0;
      md_opc    <= OpcNop;
      md_wdi    <= '0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      rsp_valid <= 1'b0;

      // md_clk is low for the first CLK_DIV cycles of a pulse, high for the rest.
      if (pulse_on && !pulse_end) begin
        cnt    <= cnt + 32'd1;
        md_clk <= (cnt + 32'd1) >= HalfLen;
      end

      case (state)
        StIdle: begin
          if (cmd_valid) begin
            addr_q   <= cmd_addr;
            wdata_q  <= cmd_wdata;
            write_q  <= cmd_write;
            relock_q <= cmd_write && cmd_relock;
            rsp_err  <= 1'b0;
            state    <= StAddr;
          end
        end

        StAddr: begin
          if (!pulse_on) begin
            pulse_on <= 1'b1;
            cnt      <= '0;
            md_clk   <= 1'b0;
            md_opc   <= OpcAddr;
            md_wdi   <= addr_q;
          end else if (pulse_end) begin
            cnt    <= '0;
            md_clk <= 1'b0;
            md_opc <= write_q ? OpcWrite : OpcRead;
            if (write_q) md_wdi <= wdata_q;
            state  <= StData;
          end
        end

        StData: begin
          if (pulse_end) begin
            cnt    <= '0;
            md_clk <= 1'b0;
            md_opc <= OpcNop;
            if (!write_q) begin
              state <= StCapt;
            end else begin
              pulse_on <= 1'b0;
              if (relock_q) begin
                pll_reset <= 1'b1;
                state     <= StRst;
              end else begin
                rsp_valid <= 1'b1;
                state     <= StResp;
              end
            end
          end
        end

        StCapt: begin
          // Sample on the edge where md_clk falls at the end of the pulse.
          if (pulse_end) begin
            pulse_on  <= 1'b0;
            cnt       <= '0;
            md_clk    <= 1'b0;
            rsp_rdata <= md_rdo;
            rsp_valid <= 1'b1;
            state     <= StResp;
          end
        end

        StRst: begin
          if (cnt == RstLast) begin
            pll_reset <= 1'b0;
            cnt       <= '0;
            state     <= StLockw;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        StLockw: begin
          // Lock takes priority over a timeout on the same cycle.
          if (lock_s) begin
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            cnt       <= '0;
            state     <= StResp;
          end else if (cnt == LockLast) begin
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            cnt       <= '0;
            state     <= StResp;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        StResp: state <= StIdle;

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/pll_mdrp_ctrl.md
Name: pll_mdrp_ctrl

Overview:
Initiator for the PLL dynamic-reconfiguration (MD) port on the GW5A PLLA wrappers. It drives md_clk, md_opc, md_ainc and md_wdi, and samples md_rdo.
A host issues single-byte register reads or writes over a valid/ready command interface. After a write, the block can optionally pulse PLL reset and wait for lock, with a timeout.
It sits in the clock/reset subsystem, between the control register file and the PLL wrapper instance.

Parameters:
CLK_DIV, 4, clk cycles per md_clk half-period (≥1); one MD pulse = 2*CLK_DIV cycles
RST_CYCLES, 32, clk cycles pll_reset is held high during relock
LOCK_TIMEOUT, 65536, clk cycles to wait for synchronized lock before error

Ports:
clk  in  1  system clock; md_clk is derived from it
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1=write, 0=read
cmd_addr  in  8  MD register address
cmd_wdata  in  8  write data
cmd_relock  in  1  write only: run reset/lock sequence after data phase
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  8  read data; valid with rsp_valid, holds value until next read
rsp_err  out  1  lock timeout flag; valid with rsp_valid
busy  out  1  high whenever state != IDLE
pll_lock  in  1  PLL lock, asynchronous
pll_reset  out  1  to PLL reset
md_clk  out  1  MD clock
md_opc  out  2  00 NOP, 01 WRITE, 10 READ, 11 ADDR
md_ainc  out  1  tied-off register, always 0
md_wdi  out  8  MD write data/address
md_rdo  in  8  MD read data

Behaviour:
- Reset values:
  - cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0
  - pll_reset=0, md_clk=0, md_opc=00, md_ainc=0, md_wdi=0
  - state=IDLE, all counters cleared
- Reset mid-operation: outputs return to reset values on the next edge (pll_reset drops immediately). The in-flight command is dropped and no rsp_valid is produced.
- pll_lock passes through a 2-FF synchronizer; lock_s is the synchronized value.
- Command handshake:
  - Accepted on a clk edge where cmd_valid && cmd_ready.
  - addr, wdata, write and relock are latched at acceptance.
  - cmd_relock is ignored for reads.
  - cmd_valid while busy is ignored; cmd_ready=0.
- MD pulse timing:
  - md_opc and md_wdi are updated only on the cycle a pulse starts, while md_clk=0.
  - md_clk stays low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - md_opc and md_wdi are stable across the whole pulse.
  - md_opc returns to 00 in IDLE.
- States:
  - IDLE → ADDR on accept.
  - ADDR: one pulse, opc=11, wdi=addr → DATA.
  - DATA: one pulse; opc=01 with wdi=wdata for a write, opc=10 for a read.
    - read → CAPT
    - write with relock → RST
    - write without relock → RESP
  - CAPT: one pulse with opc=00. md_rdo is sampled into rsp_rdata on the clk edge where md_clk goes 1→0 → RESP.
  - RST: pll_reset=1 for exactly RST_CYCLES cycles, then 0 → LOCKW.
  - LOCKW: counter runs from 0.
    - lock_s=1 → RESP with rsp_err=0.
    - Counter reaches LOCK_TIMEOUT-1 without lock → RESP with rsp_err=1.
    - If lock_s rises on the final timeout cycle, lock wins and rsp_err=0.
  - RESP: rsp_valid=1 for one cycle → IDLE. cmd_ready returns to 1 on the following cycle.
- Latency with D=CLK_DIV, accept at cycle 0:
  - write, no relock: rsp_valid at cycle 4D+1
  - read: rsp_valid at cycle 6D+1
  - write with relock: rsp_valid at 4D+RST_CYCLES+1+lock wait
- rsp_err is cleared on every accept. It is updated only in RESP.
- rsp_rdata is unchanged by writes.

Test Plan:
- CLK_DIV=2, write addr=0x12 data=0x34 relock=0 → md_opc=11/md_wdi=0x12 for cycles 1–4, then 01/0x34 for cycles 5–8. md_clk toggles every 2 cycles. rsp_valid at cycle 9, rsp_err=0.
- CLK_DIV=2, read addr=0x07 with md_rdo=0x5A during CAPT → opc 11, then 10, then 00. rsp_valid at cycle 13 with rsp_rdata=0x5A.
- Write with relock, RST_CYCLES=16, pll_lock raised 10 cycles after pll_reset falls → pll_reset high exactly 16 cycles. rsp_valid about 12 cycles after reset release (10 + 2-FF sync), rsp_err=0.
- Relock with pll_lock held 0 and LOCK_TIMEOUT=100 → rsp_err=1 exactly 100 cycles into LOCKW. Next command starts with rsp_err cleared.
- Second cmd_valid asserted while busy → no md activity and not accepted. After RESP, cmd_ready=1 and the held command is accepted.
- Assert reset during DATA of a write → next edge: md_clk=0, md_opc=00, pll_reset=0, cmd_ready=1, no rsp_valid ever produced.
